// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: a - b over WIDTH cycles, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sa, sa_d, sb, sb_d, sd, sd_d, diff_d;
  logic             bw, bw_d, busy_d, done_d, borrow_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             x, y, d, bw_nx;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, a_msb_d, b_msb, b_msb_d, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  assign x     = sa[0];
  assign y     = sb[0];
  assign d     = x ^ y ^ bw;
  assign bw_nx = (~x & y) | (~(x ^ y) & bw);

  // Next-state and output logic
  always_comb begin
    state_d  = state;
    sa_d     = sa;
    sb_d     = sb;
    sd_d     = sd;
    bw_d     = bw;
    cnt_d    = cnt;
    diff_d   = diff;
    borrow_d = borrow_out;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb;
    b_msb_d  = b_msb;
    ovf_d    = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        sa_d  = sa >> 1;
        sb_d  = sb >> 1;
        sd_d  = WIDTH'({d, sd} >> 1);
        bw_d  = bw_nx;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          diff_d   = sd_d;
          borrow_d = bw_nx;
          done_d   = 1'b1;
          state_d  = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb != b_msb) & (d != a_msb);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      sa         <= sa_d;
      sb         <= sb_d;
      sd         <= sd_d;
      bw         <= bw_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      diff       <= diff_d;
      borrow_out <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= a_msb_d;
      b_msb      <= b_msb_d;
      ovf        <= ovf_d;
`endif
    end
  end

endmodule
